// File: rtl/pixel_word_packer.sv
// Serial-to-parallel pixel packer. Bits arrive LSB first, completed (or
// flushed) words go into a small FIFO, and the FIFO head is handed to a
// downstream register once per tick period.
module pixel_word_packer #(
    parameter int NrOfBits   = 8,
    parameter int TickPeriod = 4,
    parameter int FifoDepth  = 4
) (
    input  logic                         Clock,
    input  logic                         Reset,
    input  logic                         BitIn,
    input  logic                         BitValid,
    output logic                         BitReady,
    input  logic                         Flush,
    output logic [NrOfBits-1:0]          D,
    output logic                         ClockEnable,
    output logic                         Tick,
    output logic [$clog2(FifoDepth):0]   Level
);

    localparam int PW = $clog2(FifoDepth);
    localparam int LW = PW + 1;
    localparam int CW = (NrOfBits > 1) ? $clog2(NrOfBits) : 1;

    localparam logic [CW-1:0] LAST_BIT  = CW'(NrOfBits - 1);
    localparam logic [LW-1:0] FULL_LVL  = LW'(FifoDepth);
    localparam logic [7:0]    LAST_TICK = 8'(TickPeriod - 1);

    logic [NrOfBits-1:0] mem [FifoDepth];
    logic [PW-1:0]       rd_ptr;
    logic [PW-1:0]       wr_ptr;
    logic [LW-1:0]       level;
    logic [CW-1:0]       bit_cnt;
    logic [NrOfBits-1:0] shift;
    logic [7:0]          tick_cnt;

    logic                full;
    logic                accept;
    logic                complete;
    logic                have_bits;
    logic                push;
    logic                pop;
    logic                tick_raw;
    logic [NrOfBits-1:0] word;

    // Handshake, push/pop decisions and the word as it looks after this cycle's bit.
    // Outputs are gated by Reset so they read idle values while reset is held.
    always_comb begin
        full      = (level == FULL_LVL);
        // Only stall when the incoming bit would complete a word with nowhere to go.
        BitReady  = !Reset || !(full && bit_cnt == LAST_BIT);
        accept    = BitValid && BitReady;
        word      = shift;
        if (accept) word[bit_cnt] = BitIn;
        complete  = accept && (bit_cnt == LAST_BIT);
        // Flush considers the bit accepted this cycle, so a coinciding bit is
        // included and a completing bit yields a single push.
        have_bits = (bit_cnt != '0) || accept;
        push      = complete || (Flush && !full && have_bits);
        tick_raw  = (tick_cnt == LAST_TICK);
        pop       = Reset && tick_raw && (level != '0);
        Tick        = Reset ? tick_raw : (TickPeriod == 1);
        ClockEnable = pop;
        D           = (Reset && level != '0) ? mem[rd_ptr] : '0;
        Level       = level;
    end

    // Control state: tick counter, bit assembly, FIFO pointers and occupancy.
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            tick_cnt <= '0;
            bit_cnt  <= '0;
            shift    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            level    <= '0;
        end else begin
            tick_cnt <= tick_raw ? 8'd0 : tick_cnt + 8'd1;
            if (push) begin
                // Shift register restarts at zero so flushed words are zero-padded.
                wr_ptr  <= wr_ptr + 1'b1;
                shift   <= '0;
                bit_cnt <= '0;
            end else if (accept) begin
                shift   <= word;
                bit_cnt <= bit_cnt + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    // Word storage; contents are don't-care until written, so no reset.
    always_ff @(posedge Clock) begin
        if (Reset && push) mem[wr_ptr] <= word;
    end

endmodule

// File: doc/pixel_word_packer.md
PIXEL_WORD_PACKER -- requirements
Module: pixel_word_packer

Interface
REQ-001 The block SHALL have parameter NrOfBits, default 8: width of a packed word and of D.
REQ-002 The block SHALL have parameter TickPeriod, default 4: Tick repeats every TickPeriod cycles; legal range 1..255.
REQ-003 The block SHALL have parameter FifoDepth, default 4: word buffer entries; power of two, at least 2.
REQ-004 Clock  input  1  sole clock; all state changes on its rising edge.
REQ-005 Reset  input  1  synchronous, active-low reset, sampled on the Clock rising edge.
REQ-006 BitIn  input  1  serial pixel bit.
REQ-007 BitValid  input  1  BitIn is offered this cycle.
REQ-008 BitReady  output  1  the packer accepts BitIn this cycle.
REQ-009 Flush  input  1  one-cycle request to emit the partial word, zero-padded.
REQ-010 D  output  NrOfBits  FIFO head word, feeding the downstream register's D.
REQ-011 ClockEnable  output  1  a word is delivered downstream this cycle.
REQ-012 Tick  output  1  periodic delivery strobe, feeding the downstream register's Tick.
REQ-013 Level  output  clog2(FifoDepth)+1  number of words currently buffered.

Function
REQ-014 A bit SHALL be accepted on a rising edge where BitValid and BitReady are both 1; it is written at shift position bit_cnt, LSB first, and bit_cnt then increments.
REQ-015 When the accepted bit fills position NrOfBits-1, the completed word SHALL be pushed into the FIFO on that same edge and bit_cnt SHALL return to 0.
REQ-016 BitReady SHALL be 0 only when Level==FifoDepth and bit_cnt==NrOfBits-1; a pop in the same cycle does not raise it.
REQ-017 A push SHALL be permitted only if Level<FifoDepth at the start of the cycle.
REQ-018 The tick counter SHALL count 0..TickPeriod-1 and wrap; Tick SHALL be combinationally 1 iff the counter equals TickPeriod-1; with TickPeriod=1, Tick SHALL be constantly 1.
REQ-019 ClockEnable SHALL equal Tick AND (Level>0); when it is 1, the head entry SHALL be popped on that edge.
REQ-020 D SHALL show the head entry whenever Level>0 and SHALL be all zeros when Level==0.
REQ-021 When a push and a pop occur on the same edge, Level SHALL stay unchanged and FIFO order SHALL be preserved.
REQ-022 FIFO pointers SHALL wrap modulo FifoDepth; words SHALL never be lost or duplicated.
REQ-023 Flush with bit_cnt>0 and a push permitted SHALL push the partial word with the unfilled upper bits at 0, then set bit_cnt to 0.
REQ-024 Flush with bit_cnt==0 SHALL have no effect.
REQ-025 Flush while the FIFO is full SHALL be ignored; the requester re-asserts it.
REQ-026 If Flush and an accepted bit coincide, the bit SHALL be included first; if that bit completes the word, only one push SHALL occur.
REQ-027 Underflow and overflow SHALL be impossible by construction; no error flag is provided.

Reset
REQ-028 While Reset==0 at a rising edge, the following SHALL be cleared to 0: bit_cnt, the shift register, the FIFO pointers, Level and the tick counter.
REQ-029 While Reset==0, Tick, ClockEnable and D SHALL be 0 and BitReady SHALL be 1, unless TickPeriod==1, where Tick is 1 but ClockEnable stays 0.
REQ-030 Reset asserted mid-word or mid-burst SHALL discard all partial and buffered data; no word SHALL be delivered afterwards from before the reset.
REQ-031 After reset release, the first Tick SHALL occur in the TickPeriod-th cycle, i.e. counter value TickPeriod-1.

Verification
REQ-032 Defaults: feed bits 1,0,1,1,0,0,1,0 on consecutive cycles -> Level becomes 1, and on the next Tick D==8'h4D with ClockEnable=1 for exactly one cycle.
REQ-033 Feed 3 bits 1,1,1, then pulse Flush -> word 8'h07 pushed, bit_cnt=0; Flush with bit_cnt=0 -> Level unchanged.
REQ-034 Hold Tick off (long TickPeriod), push 4 words, then supply 7 more bits -> Level=4 and BitReady=0 at bit 8 until the next pop; the order of the first four words is preserved.
REQ-035 At Level=2, complete a word on the same edge as a Tick pop -> Level stays 2, the popped word is the oldest, and the new word is last.
REQ-036 Assert Reset for 1 cycle with Level=3 and bit_cnt=5 -> Level=0, D=0, no ClockEnable, and the first Tick arrives TickPeriod cycles after release.
REQ-037 With TickPeriod=1, stream 24 bits -> three words, each delivered the cycle after its push completes, in order, with no loss.
